mac_pipe_param: RTL and testbench
=================================

// Module: mac_pipe_param
// PURPOSE
//  Parametrised pipelined signed/unsigned multiply-accumulate unit for NN dot products.
//  Replaces the fixed 14b/5-stage MAC with configurable widths, multiplier depth and overflow mode.
//  Adds a per-sample accumulator clear (clr_in) and a sticky saturation flag.
//  Sits between the weight/activation feeders and the activation/output stage of a neuron.
// PARAMETERS
//  IN_W        14  width of operands a, b
//  ACC_W       28  accumulator/output width; must be >= 2*IN_W
//  MULT_STAGES 5   pipeline registers in the multiplier (>=1); behavioural product + shift regs
//  SAT_EN      1   1: saturate accumulator at ACC_W limits; 0: two's-complement wrap
//  SIGNED      1   1: a, b, f signed; 0: unsigned (saturation clamps at 0 / 2^ACC_W-1)
// PORTS
//  clk        in   1      clock
//  reset_n    in   1      reset
//  a          in   IN_W   operand A, sampled when valid_in=1
//  b          in   IN_W   operand B, sampled when valid_in=1
//  valid_in   in   1      a/b/clr_in valid this cycle
//  clr_in     in   1      with valid_in: this product starts a new sum (f <= product)
//  f          out  ACC_W  accumulator value
//  valid_out  out  1      f updated by a valid sample this cycle
//  sat_flag   out  1      sticky: saturation occurred since last clear
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  Reset (reset_n=0): f=0, valid_out=0, sat_flag=0, all pipeline valid/clr bits=0; data regs
//    need not be reset. Takes effect immediately, independent of clk.
//  Pipeline: input reg (1) -> MULT_STAGES product regs -> accumulator reg (1).
//    Latency L = MULT_STAGES+2: valid_in at edge t -> valid_out=1 and new f after edge t+L.
//  valid and clr travel in a shift register alongside data; bubbles (valid_in=0) pass through,
//    leave f and sat_flag unchanged, and give valid_out=0 in that slot. Full throughput, no stall.
//  Product p = a*b (2*IN_W bits), sign-/zero-extended to ACC_W per SIGNED.
//  Accumulate slot with valid=1:
//    clr=1: f <= p; sat_flag <= 0 (p always fits, no saturation).
//    clr=0: s = f + p. Overflow if (SIGNED) operand signs equal and s sign differs,
//           (unsigned) carry out of ACC_W.
//           SAT_EN=1 & overflow: f <= max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) per sign of p;
//             unsigned: 2^ACC_W-1. sat_flag <= 1.
//           SAT_EN=0: f <= s (wrapped); sat_flag unchanged (never set).
//  Once saturated, further same-sign products keep f at the limit; opposite-sign products
//    move f off the limit normally.
//  valid_out is a single-cycle pulse per valid sample; f holds between valid slots.
//  clr_in with valid_in=0 is ignored.
//  First sample after reset: f=0, so clr_in=0 accumulates onto 0 (equivalent to clear).
//  Reset mid-operation: in-flight samples are dropped; no valid_out for them after release.
//  Deassertion of reset_n is synchronised externally; the first valid_in is accepted at the
//    first edge after release.
// TESTING  (IN_W=14, ACC_W=28, MULT_STAGES=5, SIGNED=1, L=7 unless noted)
//  1 Latency: a=3,b=4,clr=1 at edge 0 -> valid_out=1 after edge 7 only, f=12, sat_flag=0.
//  2 Pos sat: a=b=-8192 x3 back-to-back, first clr=1 -> f=67108864, 134217727,
//    134217727; sat_flag=1 from 2nd valid_out.
//  3 Neg sat: a=-8192,b=8191 x3, first clr=1 -> f=-67100672, -134201344, -134217728;
//    sat_flag=1 on 3rd. Then clr=1,a=1,b=1 -> f=1, sat_flag=0.
//  4 Bubbles: valid 1,0,1 with (2,5,clr=1),(x),(-3,7) -> valid_out 1,0,1 at edges 7,8,9;
//    f=10, 10, -11.
//  5 Async reset: 4 samples in flight, reset_n low mid-cycle for 2 cycles -> f=0,
//    valid_out=0 immediately (before next edge); no valid_out for dropped samples after release.
//  6 SAT_EN=0: a=b=-8192 x2, first clr=1 -> f=67108864, then -134217728; sat_flag stays 0.

Source files
------------

// File: rtl/mac_pipe_param.sv
// rtl/mac_pipe_param.sv - parametrised pipelined multiply-accumulate with optional saturation
module mac_pipe_param #(
    parameter int IN_W        = 14,
    parameter int ACC_W       = 28,
    parameter int MULT_STAGES = 5,
    parameter int SAT_EN      = 1,
    parameter int SIGNED      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    input  logic             clr_in,
    output logic [ACC_W-1:0] f,
    output logic             valid_out,
    output logic             sat_flag
);
    localparam int PW = 2 * IN_W;

    logic [IN_W-1:0]        a_q;
    logic [IN_W-1:0]        b_q;
    logic                   v_in_q;
    logic                   c_in_q;
    logic [PW-1:0]          a_ext;
    logic [PW-1:0]          b_ext;
    logic [PW-1:0]          prod;
    logic [PW-1:0]          prod_q [MULT_STAGES];
    logic [MULT_STAGES-1:0] v_q;
    logic [MULT_STAGES-1:0] c_q;
    logic [PW-1:0]          prod_last;
    logic                   v_last;
    logic                   c_last;
    logic [ACC_W-1:0]       p_ext;
    logic [ACC_W:0]         sum;
    logic                   ovf;
    logic [ACC_W-1:0]       sat_val;

    // Low 2*IN_W bits of the product of extended operands are correct for both signednesses.
    assign a_ext = (SIGNED != 0) ? {{IN_W{a_q[IN_W-1]}}, a_q} : {{IN_W{1'b0}}, a_q};
    assign b_ext = (SIGNED != 0) ? {{IN_W{b_q[IN_W-1]}}, b_q} : {{IN_W{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    assign prod_last = prod_q[MULT_STAGES-1];
    assign v_last    = v_q[MULT_STAGES-1];
    assign c_last    = c_q[MULT_STAGES-1];

    // Double inversion fills the upper accumulator bits with ones for negative products.
    assign p_ext = (SIGNED != 0 && prod_last[PW-1]) ? ~ACC_W'(~prod_last) : ACC_W'(prod_last);
    assign sum   = {1'b0, f} + {1'b0, p_ext};

    always_comb begin
        ovf     = 1'b0;
        sat_val = '1;
        if (SIGNED != 0) begin
            ovf     = (f[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != p_ext[ACC_W-1]);
            sat_val = p_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf     = sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        a_q       <= a;
        b_q       <= b;
        prod_q[0] <= prod;
        for (int i = 1; i < MULT_STAGES; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_in_q <= 1'b0;
            c_in_q <= 1'b0;
            v_q    <= '0;
            c_q    <= '0;
        end else begin
            v_in_q <= valid_in;
            c_in_q <= clr_in & valid_in;
            v_q[0] <= v_in_q;
            c_q[0] <= c_in_q;
            for (int i = 1; i < MULT_STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                c_q[i] <= c_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f         <= '0;
            valid_out <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            valid_out <= v_last;
            if (v_last) begin
                if (c_last) begin
                    f        <= p_ext;
                    sat_flag <= 1'b0;
                end else if (SAT_EN != 0 && ovf) begin
                    f        <= sat_val;
                    sat_flag <= 1'b1;
                end else begin
                    f        <= sum[ACC_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe_param.sv
// tb/tb_mac_pipe_param.sv - scoreboard bench for saturating and wrapping mac_pipe_param
module tb_mac_pipe_param;
    localparam int     L    = 7;
    localparam longint MAXV = 134217727;
    localparam longint MINV = -134217728;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [13:0] a = '0;
    logic [13:0] b = '0;
    logic        valid_in = 1'b0;
    logic        clr_in = 1'b0;
    logic [27:0] f1, f0;
    logic        vo1, vo0, sat1, sat0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int          due;
        logic [27:0] f1;
        logic        s1;
        logic [27:0] f0;
        logic        s0;
    } exp_t;

    exp_t        q[$];
    longint      m_f1 = 0, m_f0 = 0;
    logic        m_s1 = 1'b0, m_s0 = 1'b0;
    logic [27:0] h_f1 = '0, h_f0 = '0;
    logic        h_s1 = 1'b0, h_s0 = 1'b0;

    mac_pipe_param #(.IN_W(14), .ACC_W(28), .MULT_STAGES(5), .SAT_EN(1), .SIGNED(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .valid_in(valid_in), .clr_in(clr_in),
        .f(f1), .valid_out(vo1), .sat_flag(sat1)
    );

    mac_pipe_param #(.IN_W(14), .ACC_W(28), .MULT_STAGES(5), .SAT_EN(0), .SIGNED(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .valid_in(valid_in), .clr_in(clr_in),
        .f(f0), .valid_out(vo0), .sat_flag(sat0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic v, input int av, input int bv, input logic c);
        longint p, s;
        valid_in = v;
        a        = 14'(av);
        b        = 14'(bv);
        clr_in   = c;
        if (v) begin
            p = longint'(av) * longint'(bv);
            if (c) begin
                m_f1 = p; m_s1 = 1'b0; m_f0 = p; m_s0 = 1'b0;
            end else begin
                s = m_f1 + p;
                if (s > MAXV) begin m_f1 = MAXV; m_s1 = 1'b1; end
                else if (s < MINV) begin m_f1 = MINV; m_s1 = 1'b1; end
                else m_f1 = s;
                s = (m_f0 + p) & 64'h0FFF_FFFF;
                m_f0 = (s > MAXV) ? s - 64'sd268435456 : s;
            end
            q.push_back('{cyc + L, 28'(m_f1), m_s1, 28'(m_f0), m_s0});
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({vo1, vo0, sat1, sat0, f1, f0} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_async: got vo=%b/%b sat=%b/%b f=%0d/%0d, want all 0", vo1, vo0, sat1, sat0, $signed(f1), $signed(f0));
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({vo1, vo0, sat1, sat0, f1, f0} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_held: got vo=%b/%b sat=%b/%b f=%0d/%0d, want all 0", vo1, vo0, sat1, sat0, $signed(f1), $signed(f0));
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_latency();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(1'b1, 3, 4, 1'b1); else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL latency cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL latency_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
    endtask

    task automatic test_pos_sat();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (i < 3) drive(1'b1, -8192, -8192, i == 0); else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL pos_sat cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL pos_sat_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
    endtask

    task automatic test_neg_sat();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i < 3) drive(1'b1, -8192, 8191, i == 0);
            else if (i == 3) drive(1'b1, 1, 1, 1'b1);
            else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL neg_sat cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL neg_sat_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
    endtask

    task automatic test_bubbles();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(1'b1, 2, 5, 1'b1);
            else if (i == 1) drive(1'b0, 1234, -77, 1'b1);
            else if (i == 2) drive(1'b1, -3, 7, 1'b0);
            else if (i == 4) drive(1'b0, 8191, 8191, 1'b1);
            else if (i == 5) drive(1'b1, -8192, -1, 1'b0);
            else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL bubbles cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL bubbles_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (i < 8) drive(1'b1, -8192, -8192, i == 0); else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL pre_reset cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL pre_reset_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({vo1, vo0, sat1, sat0, f1, f0} !== 60'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got vo=%b/%b sat=%b/%b f=%0d/%0d, want all 0", vo1, vo0, sat1, sat0, $signed(f1), $signed(f0));
        end
        q.delete();
        m_f1 = 0; m_f0 = 0; m_s1 = 1'b0; m_s0 = 1'b0;
        h_f1 = '0; h_f0 = '0; h_s1 = 1'b0; h_s0 = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 4) drive(1'b1, 100, -3, 1'b0);
            else if (i == 5) drive(1'b1, 7, 7, 1'b0);
            else drive(1'b0, 0, 0, 1'b0);
            @(negedge clk);
            n_tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if ({vo1, sat1, f1, vo0, sat0, f0} !== {1'b1, e.s1, e.f1, 1'b1, e.s0, e.f0}) begin
                    n_fail++;
                    $display("FAIL post_reset cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=1 sat=%b/%b f=%0d/%0d",
                             cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), e.s1, e.s0, $signed(e.f1), $signed(e.f0));
                end
                h_f1 = e.f1; h_s1 = e.s1; h_f0 = e.f0; h_s0 = e.s0;
            end else if ({vo1, vo0, sat1, sat0, f1, f0} !== {2'b00, h_s1, h_s0, h_f1, h_f0}) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc=%0d: got vo=%b/%b sat=%b/%b f=%0d/%0d, want vo=0 sat=%b/%b f=%0d/%0d",
                         cyc, vo1, vo0, sat1, sat0, $signed(f1), $signed(f0), h_s1, h_s0, $signed(h_f1), $signed(h_f0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pos_sat();
        test_neg_sat();
        test_bubbles();
        test_async_reset();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding samples, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
